// File: rtl/jump_redirect_ctrl.sv
// Sequences JAL/JALR through the combinational jump-target unit, then
// either redirects fetch (with link writeback) or raises a misaligned trap.
module jump_redirect_ctrl #(
    parameter logic [5:0] SEL_JAL  = 6'b000011,
    parameter logic [5:0] SEL_JALR = 6'b000100,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [5:0]       ex_aluSelect,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_imm,
    output logic [31:0]      jt_rs1,
    output logic [31:0]      jt_imm,
    output logic [5:0]       jt_aluSelect,
    input  logic [31:0]      jt_next_pc,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             wb_valid,
    output logic [31:0]      wb_data,
    output logic             trap_valid,
    input  logic             trap_ready,
    output logic [31:0]      trap_tval,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REDIRECT,
        TRAP
    } state_t;

    state_t state, state_next;

    logic [31:0]      rs1_q;
    logic [31:0]      imm_q;
    logic [5:0]       sel_q;
    logic [31:0]      link_q;
    logic [31:0]      target_q;
    logic [CNT_W-1:0] count_q;

    logic is_jump;
    logic accept;
    logic done;

    assign is_jump = (ex_aluSelect == SEL_JAL) || (ex_aluSelect == SEL_JALR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus all handshake outputs; wb_valid is the only one
    // that looks at a live input.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        done           = 1'b0;
        ex_ready       = 1'b0;
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        flush          = 1'b0;
        wb_valid       = 1'b0;
        unique case (state)
            IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid && is_jump) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                flush      = 1'b1;
                state_next = jt_next_pc[1] ? TRAP : REDIRECT;
            end
            REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    wb_valid   = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            TRAP: begin
                trap_valid = 1'b1;
                if (trap_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q    <= '0;
            imm_q    <= '0;
            sel_q    <= '0;
            link_q   <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                rs1_q  <= ex_rs1;
                imm_q  <= ex_imm;
                sel_q  <= ex_aluSelect;
                link_q <= ex_pc + 32'd4;
            end
            // Bit 0 is left as the unit produced it; JALR masking is its job.
            if (state == CALC) begin
                target_q <= jt_next_pc;
            end
            if (done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign jt_rs1         = rs1_q;
    assign jt_imm         = imm_q;
    assign jt_aluSelect   = sel_q;
    assign redirect_pc    = target_q;
    assign trap_tval      = target_q;
    assign wb_data        = link_q;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Randomized bench for jump_redirect_ctrl against a transaction-level model,
// plus directed literal checks for the main scenarios.
module tb_jump_redirect_ctrl;

    localparam int CW = 4;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] JALR = 6'b000100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_ready;
    logic [5:0]    ex_aluSelect = '0;
    logic [31:0]   ex_pc = '0;
    logic [31:0]   ex_rs1 = '0;
    logic [31:0]   ex_imm = '0;
    logic [31:0]   jt_rs1;
    logic [31:0]   jt_imm;
    logic [5:0]    jt_aluSelect;
    logic [31:0]   jt_next_pc;
    logic          redirect_valid;
    logic          redirect_ready = 1'b0;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic          wb_valid;
    logic [31:0]   wb_data;
    logic          trap_valid;
    logic          trap_ready = 1'b0;
    logic [31:0]   trap_tval;
    logic [CW-1:0] redirect_count;

    int n_vec = 0;
    int n_err = 0;

    jump_redirect_ctrl #(
        .SEL_JAL (JAL),
        .SEL_JALR(JALR),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_aluSelect  (ex_aluSelect),
        .ex_pc         (ex_pc),
        .ex_rs1        (ex_rs1),
        .ex_imm        (ex_imm),
        .jt_rs1        (jt_rs1),
        .jt_imm        (jt_imm),
        .jt_aluSelect  (jt_aluSelect),
        .jt_next_pc    (jt_next_pc),
        .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .trap_valid    (trap_valid),
        .trap_ready    (trap_ready),
        .trap_tval     (trap_tval),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // Jump-target unit stand-in.
    always_comb begin
        if (jt_aluSelect == JALR) jt_next_pc = (jt_rs1 + jt_imm) & ~32'h1;
        else                      jt_next_pc = jt_imm;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: one job in flight, age = cycles since acceptance.
    logic          m_pend = 1'b0;
    int            m_age = 0;
    logic          m_trap = 1'b0;
    logic [31:0]   m_target = '0;
    logic [31:0]   m_link = '0;
    logic [31:0]   m_rs1 = '0;
    logic [31:0]   m_imm = '0;
    logic [5:0]    m_sel = '0;
    logic [CW-1:0] m_count = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend  = 1'b0;
            m_age   = 0;
            m_count = '0;
            m_rs1   = '0;
            m_imm   = '0;
            m_sel   = '0;
        end else if (!m_pend) begin
            if (ex_valid && (ex_aluSelect == JAL || ex_aluSelect == JALR)) begin
                m_pend   = 1'b1;
                m_age    = 1;
                m_rs1    = ex_rs1;
                m_imm    = ex_imm;
                m_sel    = ex_aluSelect;
                m_link   = ex_pc + 32'd4;
                m_target = (ex_aluSelect == JAL) ? ex_imm
                                                 : ((ex_rs1 + ex_imm) & ~32'h1);
                m_trap   = m_target[1];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_trap ? trap_ready : redirect_ready) begin
            m_pend = 1'b0;
            if (!m_trap) m_count = m_count + 1'b1;
        end
    end

    always @(negedge clk) begin
        logic calc, outp, rd, tr, wb;
        calc = m_pend && (m_age == 1);
        outp = m_pend && (m_age >= 2);
        rd   = outp && !m_trap;
        tr   = outp && m_trap;
        wb   = rd && redirect_ready;
        chk("ex_ready", 32'(ex_ready), 32'(!m_pend));
        chk("flush", 32'(flush), 32'(calc || rd));
        chk("redirect_valid", 32'(redirect_valid), 32'(rd));
        chk("trap_valid", 32'(trap_valid), 32'(tr));
        chk("wb_valid", 32'(wb_valid), 32'(wb));
        chk("redirect_count", 32'(redirect_count), 32'(m_count));
        if (rd) chk("redirect_pc", redirect_pc, m_target);
        if (tr) chk("trap_tval", trap_tval, m_target);
        if (wb) chk("wb_data", wb_data, m_link);
        if (m_pend || reset) begin
            chk("jt_rs1", jt_rs1, m_rs1);
            chk("jt_imm", jt_imm, m_imm);
            chk("jt_aluSelect", 32'(jt_aluSelect), 32'(m_sel));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] sel, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] imm);
        ex_valid     = 1'b1;
        ex_aluSelect = sel;
        ex_pc        = pc;
        ex_rs1       = rs1;
        ex_imm       = imm;
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        redirect_ready = 1'b1;
        #1;
        chk("rst ex_ready", 32'(ex_ready), 32'd1);
        chk("rst count", 32'(redirect_count), 32'd0);
        chk("rst redirect_valid", 32'(redirect_valid), 32'd0);

        // JAL
        step();
        req(JAL, 32'h40, 32'h0, 32'd100);
        step();
        ex_valid = 1'b0;
        chk("jal calc flush", 32'(flush), 32'd1);
        chk("jal calc ex_ready", 32'(ex_ready), 32'd0);
        step();
        chk("jal redirect_pc", redirect_pc, 32'd100);
        chk("jal wb_valid", 32'(wb_valid), 32'd1);
        chk("jal wb_data", wb_data, 32'h44);
        chk("jal flush", 32'(flush), 32'd1);
        step();
        chk("jal count", 32'(redirect_count), 32'd1);

        // Back-to-back JALR
        req(JALR, 32'h100, 32'd200, 32'd12);
        step();
        req(JALR, 32'h200, 32'd300, 32'd8);
        chk("b2b busy", 32'(ex_ready), 32'd0);
        step();
        chk("jalr redirect_pc", redirect_pc, 32'd212);
        step();
        chk("b2b idle", 32'(ex_ready), 32'd1);
        chk("b2b count", 32'(redirect_count), 32'd2);
        step();
        ex_valid = 1'b0;
        chk("b2b second accepted", 32'(ex_ready), 32'd0);
        chk("b2b jt_rs1", jt_rs1, 32'd300);
        step();
        chk("jalr2 redirect_pc", redirect_pc, 32'd308);
        step();
        chk("b2b count2", 32'(redirect_count), 32'd3);

        // Misaligned target
        trap_ready = 1'b0;
        req(JALR, 32'h300, 32'h101, 32'd1);
        step();
        ex_valid = 1'b0;
        step();
        chk("trap_valid", 32'(trap_valid), 32'd1);
        chk("trap_tval", trap_tval, 32'h102);
        chk("trap wb_valid", 32'(wb_valid), 32'd0);
        chk("trap flush", 32'(flush), 32'd0);
        step();
        chk("trap hold", 32'(trap_valid), 32'd1);
        trap_ready = 1'b1;
        step();
        chk("trap idle", 32'(ex_ready), 32'd1);
        chk("trap count", 32'(redirect_count), 32'd3);

        // Redirect back-pressure
        redirect_ready = 1'b0;
        req(JAL, 32'h80, 32'h0, 32'h200);
        step();
        ex_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp valid", 32'(redirect_valid), 32'd1);
            chk("bp pc", redirect_pc, 32'h200);
            chk("bp ex_ready", 32'(ex_ready), 32'd0);
            chk("bp wb_valid", 32'(wb_valid), 32'd0);
            step();
        end
        redirect_ready = 1'b1;
        #1;
        chk("bp wb_valid accept", 32'(wb_valid), 32'd1);
        chk("bp wb_data", wb_data, 32'h84);
        step();
        chk("bp count", 32'(redirect_count), 32'd4);

        // Ignored opcode
        req(6'b111111, 32'h500, 32'h4, 32'h8);
        step();
        ex_valid = 1'b0;
        chk("ign ex_ready", 32'(ex_ready), 32'd1);
        chk("ign flush", 32'(flush), 32'd0);
        chk("ign redirect", 32'(redirect_valid), 32'd0);

        // Reset while redirecting
        redirect_ready = 1'b0;
        req(JAL, 32'h0, 32'h0, 32'h300);
        step();
        ex_valid = 1'b0;
        step();
        chk("rr valid", 32'(redirect_valid), 32'd1);
        redirect_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rr redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rr wb_valid", 32'(wb_valid), 32'd0);
        chk("rr flush", 32'(flush), 32'd0);
        chk("rr count", 32'(redirect_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rr ex_ready", 32'(ex_ready), 32'd1);
        chk("rr count after", 32'(redirect_count), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            step();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            r = $urandom_range(0, 9);
            ex_valid       = ($urandom_range(0, 1) == 1);
            ex_aluSelect   = (r < 4) ? JAL : (r < 8) ? JALR : 6'($urandom);
            ex_pc          = $urandom;
            ex_rs1         = $urandom;
            ex_imm         = $urandom;
            redirect_ready = ($urandom_range(0, 9) < 6);
            trap_ready     = ($urandom_range(0, 9) < 6);
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jump_redirect_ctrl.md
# jump_redirect_ctrl

Sequencer for the combinational jump-target unit in the Execution Cycle. It accepts JAL/JALR requests from the EX stage, drives the unit's operands, and samples the computed target. It then checks target alignment and either redirects fetch (flushing younger stages and writing back the link address) or raises a misaligned-target trap. It handles one request at a time and back-pressures EX while busy.

## Interface
- SEL_JAL, default 6'b000011: aluSelect code for JAL.
- SEL_JALR, default 6'b000100: aluSelect code for JALR.
- CNT_W, default 16: width of the completed-redirect counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- ex_valid  in  1  EX presents a request.
- ex_ready  out  1  block accepts a request; high only in IDLE.
- ex_aluSelect  in  6  operation code.
- ex_pc  in  32  PC of the request.
- ex_rs1  in  32  rs1 operand.
- ex_imm  in  32  immediate.
- jt_rs1  out  32  operand to the jump unit.
- jt_imm  out  32  operand to the jump unit.
- jt_aluSelect  out  6  select to the jump unit.
- jt_next_pc  in  32  target from the jump unit (combinational).
- redirect_valid  out  1  new PC is available to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  32  target.
- flush  out  1  kill IF/ID and ID/EX contents.
- wb_valid  out  1  link write strobe.
- wb_data  out  32  link value, ex_pc+4.
- trap_valid  out  1  misaligned-target trap.
- trap_ready  in  1  trap handler accepts.
- trap_tval  out  32  offending target.
- redirect_count  out  CNT_W  completed redirects, wraps.

## Operation
- States: IDLE, CALC, REDIRECT, TRAP. Encoding is free.
- IDLE:
  - ex_ready=1.
  - On ex_valid with sel==SEL_JAL or SEL_JALR: capture rs1, imm, sel and link=ex_pc+4 (mod 2^32), then go to CALC.
  - On ex_valid with any other sel: the request is consumed and ignored; stay in IDLE.
- jt_rs1/jt_imm/jt_aluSelect are driven from the capture registers in every state. Their value in IDLE is don't-care; the reset value is 0.
- CALC:
  - Sample jt_next_pc into target_q.
  - If jt_next_pc[1]==1, go to TRAP; otherwise go to REDIRECT.
  - The block does not clear bit 0. It trusts the jump unit for JALR masking.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target_q, held stable until redirect_ready.
  - On redirect_valid & redirect_ready: wb_valid=1 with wb_data=link in that same cycle, redirect_count increments, next state is IDLE.
- TRAP:
  - trap_valid=1 and trap_tval=target_q, held until trap_ready.
  - No writeback and no count increment. Next state is IDLE.
- flush=1 in CALC and REDIRECT. flush=0 in TRAP, because the trap path owns its own flush.
- wb_valid is combinational: state==REDIRECT & redirect_ready. All other outputs are decoded from registers.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All capture registers, target_q, link and redirect_count are cleared to 0.
  - redirect_valid, wb_valid, trap_valid and flush are 0; ex_ready=1 after reset deasserts.
- Latency:
  - Request accepted at edge N.
  - CALC in cycle N+1.
  - REDIRECT or TRAP valid from cycle N+2.
  - With ready already high, the block is back in IDLE after edge N+3, so back-to-back throughput is one jump per 3 cycles.
- Back-pressure: redirect_valid/trap_valid stay high, and redirect_pc/trap_tval stay stable, for any number of cycles until ready. ex_ready stays 0 throughout.
- ex_valid arriving while busy is not accepted. EX must hold it.
- Reset asserted in CALC, REDIRECT or TRAP aborts the operation: no wb_valid, no count increment.
- redirect_count wraps from 2^CNT_W-1 to 0.

## Test plan
The bench models the jump unit as: JAL -> imm; JALR -> (rs1+imm)&~1.
- JAL: ex_pc=0x40, imm=100, sel=000011, redirect_ready=1 -> redirect_pc=100 at cycle N+2, flush high in N+1..N+2, wb_valid with wb_data=0x44, redirect_count=1.
- JALR: rs1=200, imm=12, sel=000100 -> redirect_pc=212; a second JALR issued immediately after is accepted 3 cycles after the first.
- Misaligned: JALR rs1=0x101, imm=1 (target 0x102) -> trap_valid, trap_tval=0x102, no wb_valid, count unchanged; trap_ready=1 -> back to IDLE.
- Back-pressure: redirect_ready low for 4 cycles -> redirect_valid and redirect_pc stable, ex_ready=0, wb_valid only in the accept cycle.
- Ignored op: sel=111111 with ex_valid -> ex_ready=1, no flush, no redirect, state stays IDLE.
- Reset mid-REDIRECT: assert reset while redirect_valid=1 -> outputs 0 immediately, no wb_valid, count=0, ex_ready=1 after release.
